// File: rtl/rx_link_ctrl.sv
// rx_link_ctrl: comma-based byte alignment and link-lock controller.
// Hunts for a run of COM bytes to declare lock, then forwards payload bytes
// and monitors COM spacing so that a link whose commas stop arriving is dropped.
// Optional feature: define RX_LINK_CTRL_BIT_SLIP_EN to add the slip output.
// That output asks the deserializer to shift by one bit after every eight
// consecutive non-COM bytes seen while searching.
module rx_link_ctrl #(
  parameter logic [7:0] COM        = 8'hBC,
  parameter int         LOCK_COUNT = 4,
  parameter int         MAX_GAP    = 16,
  parameter int         LOSS_COUNT = 3
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       byte_stb,
  output logic       active,
  output logic       valid_out,
  output logic [7:0] data_out,
  output logic [3:0] err_cnt
`ifdef RX_LINK_CTRL_BIT_SLIP_EN
  ,
  output logic       slip
`endif
);

  // Thresholds narrowed to the width of the counters they are compared with.
  localparam logic [2:0] LOCK_L = 3'(LOCK_COUNT);
  localparam logic [4:0] GAP_L  = 5'(MAX_GAP);
  localparam logic [1:0] LOSS_L = 2'(LOSS_COUNT);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_COUNT  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t     state_r;
  logic [2:0] com_cnt_r;
  logic [4:0] gap_cnt_r;
  logic [1:0] miss_cnt_r;
`ifdef RX_LINK_CTRL_BIT_SLIP_EN
  logic [2:0] slip_cnt_r;
`endif

  logic       is_com_s;
  logic [2:0] com_inc_s;
  logic [4:0] gap_inc_s;
  logic [1:0] miss_inc_s;
  logic       lock_hit_s;
  logic       gap_hit_s;
  logic       loss_hit_s;
  logic [3:0] err_inc_s;

  // Next-value helpers shared by the state machine below.
  always_comb begin
    is_com_s   = (byte_in == COM);
    com_inc_s  = com_cnt_r + 3'd1;
    gap_inc_s  = gap_cnt_r + 5'd1;
    miss_inc_s = miss_cnt_r + 2'd1;
    lock_hit_s = (com_inc_s == LOCK_L);
    gap_hit_s  = (gap_inc_s == GAP_L);
    loss_hit_s = gap_hit_s && (miss_inc_s == LOSS_L);
    if (err_cnt == 4'hF) begin
      err_inc_s = 4'hF;
    end else begin
      err_inc_s = err_cnt + 4'd1;
    end
  end

  // Lock state machine with all counters and registered outputs.
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_SEARCH;
      com_cnt_r  <= 3'd0;
      gap_cnt_r  <= 5'd0;
      miss_cnt_r <= 2'd0;
      active     <= 1'b0;
      valid_out  <= 1'b0;
      data_out   <= 8'h00;
      err_cnt    <= 4'd0;
`ifdef RX_LINK_CTRL_BIT_SLIP_EN
      slip_cnt_r <= 3'd0;
      slip       <= 1'b0;
`endif
    end else begin
      // Pulsed outputs fall back to zero unless a strobe raises them.
      valid_out <= 1'b0;
`ifdef RX_LINK_CTRL_BIT_SLIP_EN
      slip      <= 1'b0;
`endif
      if (byte_stb) begin
        case (state_r)
          ST_SEARCH, ST_COUNT: begin
            if (is_com_s) begin
`ifdef RX_LINK_CTRL_BIT_SLIP_EN
              slip_cnt_r <= 3'd0;
`endif
              // com_cnt_r is zero in SEARCH, so LOCK_COUNT=1 locks straight away.
              if (lock_hit_s) begin
                state_r    <= ST_ACTIVE;
                active     <= 1'b1;
                com_cnt_r  <= 3'd0;
                gap_cnt_r  <= 5'd0;
                miss_cnt_r <= 2'd0;
              end else begin
                state_r   <= ST_COUNT;
                com_cnt_r <= com_inc_s;
              end
            end else begin
              state_r   <= ST_SEARCH;
              com_cnt_r <= 3'd0;
`ifdef RX_LINK_CTRL_BIT_SLIP_EN
              // Only bytes seen while already searching count toward a slip.
              if (state_r == ST_SEARCH) begin
                if (slip_cnt_r == 3'd7) begin
                  slip       <= 1'b1;
                  slip_cnt_r <= 3'd0;
                end else begin
                  slip_cnt_r <= slip_cnt_r + 3'd1;
                end
              end else begin
                slip_cnt_r <= 3'd0;
              end
`endif
            end
          end
          ST_ACTIVE: begin
            if (is_com_s) begin
              gap_cnt_r  <= 5'd0;
              miss_cnt_r <= 2'd0;
            end else begin
              // Payload is delivered even when it is the byte that drops lock.
              data_out  <= byte_in;
              valid_out <= 1'b1;
              if (loss_hit_s) begin
                state_r    <= ST_SEARCH;
                active     <= 1'b0;
                com_cnt_r  <= 3'd0;
                gap_cnt_r  <= 5'd0;
                miss_cnt_r <= 2'd0;
                err_cnt    <= err_inc_s;
              end else if (gap_hit_s) begin
                gap_cnt_r  <= 5'd0;
                miss_cnt_r <= miss_inc_s;
              end else begin
                gap_cnt_r <= gap_inc_s;
              end
            end
          end
          default: begin
            state_r    <= ST_SEARCH;
            active     <= 1'b0;
            com_cnt_r  <= 3'd0;
            gap_cnt_r  <= 5'd0;
            miss_cnt_r <= 2'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/rx_link_ctrl.md
RX_LINK_CTRL -- requirements
Module: rx_link_ctrl

Interface
REQ-001 Parameter COM, default 8'hBC: comma/alignment symbol.
REQ-002 Parameter LOCK_COUNT, default 4: consecutive COM bytes needed to declare lock (range 1..7).
REQ-003 Parameter MAX_GAP, default 16: maximum non-COM bytes allowed between COMs in ACTIVE (range 2..31).
REQ-004 Parameter LOSS_COUNT, default 3: consecutive gap violations that drop lock (range 1..3).
REQ-005 clk_4f  in  1  byte-rate clock; all logic on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-007 byte_in  in  8  raw byte from the serial-to-parallel deserializer.
REQ-008 byte_stb  in  1  byte_in holds a new byte this cycle; when 0, no state, counter or output-data update.
REQ-009 active  out  1  link locked (state ACTIVE).
REQ-010 valid_out  out  1  one-cycle pulse: data_out holds a payload byte.
REQ-011 data_out  out  8  last payload byte; holds value between pulses.
REQ-012 err_cnt  out  4  lock-loss event count, saturating.
REQ-013 slip  out  1  one-cycle bit-slip request to deserializer (present only with BIT_SLIP_EN).

Function
REQ-014 Three-state FSM: SEARCH, COUNT, ACTIVE; all outputs registered.
REQ-015 SEARCH: strobe with byte_in==COM -> COUNT, com_cnt=1; other strobes stay in SEARCH.
REQ-016 COUNT: COM strobe increments com_cnt; when incremented value equals LOCK_COUNT -> ACTIVE next cycle, gap and miss counters cleared.
REQ-017 COUNT: non-COM strobe -> SEARCH, com_cnt=0.
REQ-018 LOCK_COUNT=1: COM strobe in SEARCH goes directly to ACTIVE.
REQ-019 active=1 exactly while state is ACTIVE; asserted the cycle after the locking strobe.
REQ-020 ACTIVE, non-COM strobe: data_out<=byte_in, valid_out=1 next cycle (latency 1), gap counter +1.
REQ-021 ACTIVE, COM strobe: valid_out=0, data_out unchanged, gap and miss counters cleared.
REQ-022 Gap counter reaching MAX_GAP: miss +1, gap cleared; the byte causing it is still delivered.
REQ-023 Miss reaching LOSS_COUNT: -> SEARCH next cycle, active=0, all counters cleared, err_cnt +1 saturating at 15.
REQ-024 No valid_out pulse in SEARCH or COUNT; the locking COM and all COMs are never delivered.
REQ-025 byte_stb=0 any cycle: valid_out=0, slip=0, state and counters held.

Reset
REQ-026 reset=0 asynchronously forces: state SEARCH, active=0, valid_out=0, data_out=8'h00, err_cnt=0, slip=0, all internal counters 0.
REQ-027 Reset mid-lock or mid-COUNT discards progress; first post-reset strobe is evaluated as in SEARCH.

Configuration
REQ-028 Macro RX_LINK_CTRL_BIT_SLIP_EN defined: slip port exists; in SEARCH, every 8th consecutive non-COM strobe pulses slip=1 for one cycle and restarts the slip counter; slip counter cleared on leaving SEARCH.
REQ-029 Macro undefined: slip port and slip counter absent; all other behaviour identical.

Verification
REQ-030 Reset, then 4 strobes of 8'hBC -> active=1 the cycle after the 4th; no valid_out pulses before it.
REQ-031 Locked, strobe 8'h5A then 8'hBC -> valid_out pulse with data_out=8'h5A, none for 8'hBC.
REQ-032 In COUNT after 2 COMs, strobe 8'h00 -> SEARCH; 4 further COMs are required for active=1.
REQ-033 Locked, 48 consecutive non-COM strobes -> all 48 delivered; active=0 after the 48th; err_cnt=1.
REQ-034 With RX_LINK_CTRL_BIT_SLIP_EN, 16 non-COM strobes in SEARCH -> exactly 2 slip pulses, after the 8th and 16th.
REQ-035 Reset asserted while active=1 with byte_stb toggling -> all outputs 0 immediately, independent of clk_4f.
